// File: rtl/eth_pkg.sv
// Ethernet receive/transmit shared definitions: CRC-32 constants, MII nibble
// markers, deframer states and a byte-wise reflected CRC-32 update.
package eth_pkg;

  localparam logic [31:0] CRC32_POLY    = 32'hEDB88320;
  localparam logic [31:0] CRC32_INIT    = 32'hFFFFFFFF;
  localparam logic [31:0] CRC32_RESIDUE = 32'hDEBB20E3;

  localparam logic [3:0] PREAMBLE_NIB = 4'h5;
  localparam logic [3:0] SFD_NIB      = 4'hD;

  typedef enum logic [2:0] {
    ST_WAIT_IDLE,
    ST_IDLE,
    ST_PREAMBLE,
    ST_DATA,
    ST_DROP
  } rx_state_e;

  function automatic logic [31:0] crc32_byte(input logic [31:0] crc,
                                             input logic [7:0]  data);
    logic [31:0] c;
    c = crc ^ {24'h0, data};
    for (int unsigned i = 0; i < 8; i++) begin
      c = c[0] ? ((c >> 1) ^ CRC32_POLY) : (c >> 1);
    end
    return c;
  endfunction

endpackage

// File: rtl/crc32_d8.sv
// Byte-wide CRC-32 accumulator with synchronous clear and update enable.
module crc32_d8
  import eth_pkg::*;
(
  input  logic        clk,
  input  logic        resetn,
  input  logic        clr,
  input  logic        en,
  input  logic [7:0]  data,
  output logic [31:0] crc
);

  always_ff @(posedge clk) begin
    if (!resetn || clr) begin
      crc <= CRC32_INIT;
    end else if (en) begin
      crc <= crc32_byte(crc, data);
    end
  end

endmodule

// File: rtl/mii_rx_deframer.sv
// MII receive deframer: strips preamble/SFD, packs nibbles into bytes, checks
// FCS and streams each frame out with an end-of-frame bad flag and statistics.
module mii_rx_deframer
  import eth_pkg::*;
#(
  parameter int unsigned MAX_LEN = 1518,
  parameter int unsigned MIN_LEN = 64
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic [3:0]  mii_phy_rx_data,
  input  logic        mii_phy_dv,
  input  logic        mii_phy_rx_er,
  output logic [7:0]  m_axis_tdata,
  output logic        m_axis_tvalid,
  output logic        m_axis_tlast,
  output logic        m_axis_tuser,
  output logic [15:0] stat_good,
  output logic [15:0] stat_bad
);

  localparam int unsigned LEN_W = $clog2(MAX_LEN + 2);

  rx_state_e        state, state_n;
  logic             phase, phase_n;
  logic [3:0]       lo_nib, lo_nib_n;
  logic [7:0]       hold, hold_n;
  logic             hold_v, hold_v_n;
  logic [LEN_W-1:0] len, len_n;
  logic             err, err_n;
  logic [7:0]       tdata_n;
  logic             tvalid_n, tlast_n, tuser_n;
  logic [15:0]      good_n, bad_n;
  logic             crc_clr, crc_en;
  logic [31:0]      crc;
  logic [7:0]       rx_byte;
  logic             frame_bad;

  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    return (v == '1) ? v : v + 16'd1;
  endfunction

  assign rx_byte   = {mii_phy_rx_data, lo_nib};
  assign frame_bad = err || phase || (crc != CRC32_RESIDUE) ||
                     (len < LEN_W'(MIN_LEN));

  crc32_d8 u_crc (
    .clk    (clk),
    .resetn (resetn),
    .clr    (crc_clr),
    .en     (crc_en),
    .data   (rx_byte),
    .crc    (crc)
  );

  always_comb begin
    state_n  = state;
    phase_n  = phase;
    lo_nib_n = lo_nib;
    hold_n   = hold;
    hold_v_n = hold_v;
    len_n    = len;
    err_n    = err;
    tdata_n  = m_axis_tdata;
    tvalid_n = 1'b0;
    tlast_n  = 1'b0;
    tuser_n  = 1'b0;
    good_n   = stat_good;
    bad_n    = stat_bad;
    crc_clr  = 1'b0;
    crc_en   = 1'b0;
    unique case (state)
      ST_WAIT_IDLE: if (!mii_phy_dv) state_n = ST_IDLE;
      ST_IDLE: begin
        if (mii_phy_dv) begin
          state_n = (mii_phy_rx_data == PREAMBLE_NIB) ? ST_PREAMBLE : ST_WAIT_IDLE;
        end
      end
      ST_PREAMBLE: begin
        if (!mii_phy_dv) begin
          state_n = ST_IDLE;
        end else if (mii_phy_rx_er) begin
          state_n = ST_WAIT_IDLE;
        end else if (mii_phy_rx_data == SFD_NIB) begin
          state_n  = ST_DATA;
          crc_clr  = 1'b1;
          phase_n  = 1'b0;
          hold_v_n = 1'b0;
          len_n    = '0;
          err_n    = 1'b0;
        end else if (mii_phy_rx_data != PREAMBLE_NIB) begin
          state_n = ST_WAIT_IDLE;
        end
      end
      ST_DATA: begin
        if (!mii_phy_dv) begin
          state_n  = ST_IDLE;
          hold_v_n = 1'b0;
          if (hold_v) begin
            tvalid_n = 1'b1;
            tdata_n  = hold;
            tlast_n  = 1'b1;
            tuser_n  = frame_bad;
            if (frame_bad) bad_n = sat_inc(stat_bad);
            else           good_n = sat_inc(stat_good);
          end else begin
            bad_n = sat_inc(stat_bad);
          end
        end else begin
          if (mii_phy_rx_er) err_n = 1'b1;
          if (!phase) begin
            lo_nib_n = mii_phy_rx_data;
            phase_n  = 1'b1;
          end else if (len == LEN_W'(MAX_LEN)) begin
            // Oversize: close the frame on the held byte, discard the rest.
            state_n  = ST_DROP;
            phase_n  = 1'b0;
            hold_v_n = 1'b0;
            tvalid_n = 1'b1;
            tdata_n  = hold;
            tlast_n  = 1'b1;
            tuser_n  = 1'b1;
            bad_n    = sat_inc(stat_bad);
          end else begin
            phase_n  = 1'b0;
            crc_en   = 1'b1;
            len_n    = len + LEN_W'(1);
            hold_n   = rx_byte;
            hold_v_n = 1'b1;
            if (hold_v) begin
              tvalid_n = 1'b1;
              tdata_n  = hold;
            end
          end
        end
      end
      ST_DROP: if (!mii_phy_dv) state_n = ST_IDLE;
      default: state_n = ST_WAIT_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state         <= ST_WAIT_IDLE;
      phase         <= 1'b0;
      lo_nib        <= '0;
      hold          <= '0;
      hold_v        <= 1'b0;
      len           <= '0;
      err           <= 1'b0;
      m_axis_tdata  <= '0;
      m_axis_tvalid <= 1'b0;
      m_axis_tlast  <= 1'b0;
      m_axis_tuser  <= 1'b0;
      stat_good     <= '0;
      stat_bad      <= '0;
    end else begin
      state         <= state_n;
      phase         <= phase_n;
      lo_nib        <= lo_nib_n;
      hold          <= hold_n;
      hold_v        <= hold_v_n;
      len           <= len_n;
      err           <= err_n;
      m_axis_tdata  <= tdata_n;
      m_axis_tvalid <= tvalid_n;
      m_axis_tlast  <= tlast_n;
      m_axis_tuser  <= tuser_n;
      stat_good     <= good_n;
      stat_bad      <= bad_n;
    end
  end

endmodule

// File: tb/tb_mii_rx_deframer.sv
// Randomized frame-level bench for mii_rx_deframer with a queue-based
// reference model of frame acceptance, FCS checking and statistics.
module tb_mii_rx_deframer;

  localparam int unsigned MAX_LEN = 1518;
  localparam int unsigned MIN_LEN = 64;

  logic        clk = 1'b0;
  logic        resetn;
  logic [3:0]  rx_data;
  logic        dv, er;
  logic [7:0]  m_axis_tdata;
  logic        m_axis_tvalid, m_axis_tlast, m_axis_tuser;
  logic [15:0] stat_good, stat_bad;

  always #5 clk = ~clk;

  mii_rx_deframer #(.MAX_LEN(MAX_LEN), .MIN_LEN(MIN_LEN)) dut (
    .clk             (clk),
    .resetn          (resetn),
    .mii_phy_rx_data (rx_data),
    .mii_phy_dv      (dv),
    .mii_phy_rx_er   (er),
    .m_axis_tdata    (m_axis_tdata),
    .m_axis_tvalid   (m_axis_tvalid),
    .m_axis_tlast    (m_axis_tlast),
    .m_axis_tuser    (m_axis_tuser),
    .stat_good       (stat_good),
    .stat_bad        (stat_bad)
  );

  typedef struct {
    logic [7:0]  d;
    logic        last;
    logic        user;
    logic [15:0] g;
    logic [15:0] b;
  } beat_t;

  beat_t        exp_q[$];
  int unsigned  n_checks = 0;
  int unsigned  n_errs = 0;
  logic [15:0]  exp_good = '0;
  logic [15:0]  exp_bad = '0;
  logic [3:0]   nq[$];
  logic         eq[$];
  logic [7:0]   fb[$];
  bit           ignore_beats = 1'b0;
  int unsigned  ign_tlast = 0;
  logic         prev_valid = 1'b0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errs++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [15:0] sat(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  // Standard Ethernet FCS over the first n bytes, bit-serial LSB first.
  function automatic logic [31:0] fcs_calc(input logic [7:0] b[$], input int unsigned n);
    logic [31:0] c;
    logic        fbk;
    c = 32'hFFFFFFFF;
    for (int unsigned k = 0; k < n; k++) begin
      for (int unsigned j = 0; j < 8; j++) begin
        fbk = c[0] ^ b[k][j];
        c = c >> 1;
        if (fbk) c = c ^ 32'hEDB88320;
      end
    end
    return ~c;
  endfunction

  function automatic bit fcs_ok(input logic [7:0] b[$]);
    int unsigned s;
    s = b.size();
    if (s < 4) return 1'b0;
    return fcs_calc(b, s - 4) == {b[s-1], b[s-2], b[s-3], b[s-4]};
  endfunction

  task automatic predict();
    int unsigned n, i, start, nb;
    logic [7:0]  bytes[$];
    logic        er_any, good;
    beat_t       bt;
    n = nq.size();
    if (n == 0 || nq[0] != 4'h5) return;
    i = 1;
    while (i < n) begin
      if (eq[i]) return;
      if (nq[i] != 4'h5) break;
      i++;
    end
    if (i == n || nq[i] != 4'hD) return;
    start = i + 1;
    nb = (n - start) / 2;
    for (int unsigned k = 0; k < nb; k++) bytes.push_back({nq[start+2*k+1], nq[start+2*k]});
    er_any = 1'b0;
    for (int unsigned k = start; k < n; k++) er_any |= eq[k];
    if (nb > MAX_LEN) begin
      exp_bad = sat(exp_bad);
      for (int unsigned k = 0; k < MAX_LEN; k++) begin
        bt = '{bytes[k], k == MAX_LEN - 1, k == MAX_LEN - 1, exp_good, exp_bad};
        exp_q.push_back(bt);
      end
    end else if (nb == 0) begin
      exp_bad = sat(exp_bad);
    end else begin
      good = !er_any && ((n - start) % 2 == 0) && nb >= MIN_LEN && fcs_ok(bytes);
      if (good) exp_good = sat(exp_good);
      else      exp_bad = sat(exp_bad);
      for (int unsigned k = 0; k < nb; k++) begin
        bt = '{bytes[k], k == nb - 1, (k == nb - 1) && !good, exp_good, exp_bad};
        exp_q.push_back(bt);
      end
    end
  endtask

  task automatic make_frame(input int unsigned npay, input bit corrupt);
    logic [31:0] f;
    int unsigned idx;
    fb.delete();
    for (int unsigned k = 0; k < npay; k++) fb.push_back(8'($urandom));
    f = fcs_calc(fb, npay);
    fb.push_back(f[7:0]);
    fb.push_back(f[15:8]);
    fb.push_back(f[23:16]);
    fb.push_back(f[31:24]);
    if (corrupt) begin
      idx = $urandom_range(npay - 1, 0);
      fb[idx] = fb[idx] ^ 8'(1 << $urandom_range(7, 0));
    end
  endtask

  task automatic to_nibs();
    nq.delete();
    eq.delete();
    repeat (15) nq.push_back(4'h5);
    nq.push_back(4'hD);
    foreach (fb[k]) begin
      nq.push_back(fb[k][3:0]);
      nq.push_back(fb[k][7:4]);
    end
    foreach (nq[k]) eq.push_back(1'b0);
  endtask

  task automatic send(input int unsigned gap);
    predict();
    for (int unsigned k = 0; k < nq.size(); k++) begin
      @(negedge clk);
      dv = 1'b1;
      rx_data = nq[k];
      er = eq[k];
    end
    repeat (gap) begin
      @(negedge clk);
      dv = 1'b0;
      er = 1'b0;
      rx_data = 4'($urandom);
    end
  endtask

  task automatic check_stats();
    repeat (4) @(negedge clk);
    check("stat_good", 32'(stat_good), 32'(exp_good));
    check("stat_bad", 32'(stat_bad), 32'(exp_bad));
  endtask

  always @(negedge clk) begin
    beat_t e;
    if (m_axis_tvalid) begin
      check("tvalid_spacing", 32'(prev_valid && !m_axis_tlast), 32'd0);
      if (ignore_beats) begin
        if (m_axis_tlast) ign_tlast++;
      end else begin
        check("beat_expected", 32'(exp_q.size() != 0), 32'd1);
        if (exp_q.size() != 0) begin
          e = exp_q.pop_front();
          check("tdata", 32'(m_axis_tdata), 32'(e.d));
          check("tlast_tuser", 32'({m_axis_tlast, m_axis_tuser}), 32'({e.last, e.user}));
          if (e.last) begin
            check("eof_stat_good", 32'(stat_good), 32'(e.g));
            check("eof_stat_bad", 32'(stat_bad), 32'(e.b));
          end
        end
      end
    end
    prev_valid = m_axis_tvalid;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("Result: errors=%0d of %0d checks", n_errs + 1, n_checks + 1);
    $fatal(1);
  end

  initial begin
    resetn = 1'b0;
    dv = 1'b0;
    er = 1'b0;
    rx_data = '0;
    repeat (3) @(negedge clk);
    check("rst_tvalid", 32'(m_axis_tvalid), 32'd0);
    check("rst_tlast", 32'(m_axis_tlast), 32'd0);
    check("rst_tuser", 32'(m_axis_tuser), 32'd0);
    check("rst_tdata", 32'(m_axis_tdata), 32'd0);
    check("rst_stat_good", 32'(stat_good), 32'd0);
    check("rst_stat_bad", 32'(stat_bad), 32'd0);
    resetn = 1'b1;
    repeat (3) @(negedge clk);

    // Good minimum-size frame, then the same with one bit flipped.
    make_frame(60, 1'b0); to_nibs(); send(3);
    make_frame(60, 1'b1); to_nibs(); send(3);
    check_stats();

    // rx_er on the low nibble of data byte 10.
    make_frame(60, 1'b0); to_nibs(); eq[16 + 20] = 1'b1; send(3);
    check_stats();

    // Oversize frame followed by a good frame.
    make_frame(MAX_LEN - 3, 1'b0); to_nibs(); send(3);
    make_frame(80, 1'b0); to_nibs(); send(3);
    // Exactly maximum length.
    make_frame(MAX_LEN - 4, 1'b0); to_nibs(); send(3);
    check_stats();

    // Broken preamble, runt, odd-nibble frame.
    make_frame(60, 1'b0); to_nibs(); nq[5] = 4'h3; send(3);
    make_frame(36, 1'b0); to_nibs(); send(3);
    make_frame(60, 1'b0); to_nibs(); nq.push_back(4'hA); eq.push_back(1'b0); send(3);
    check_stats();

    // SFD with no complete byte, and with a single trailing nibble.
    make_frame(60, 1'b0); to_nibs(); nq = nq[0:15]; eq = eq[0:15]; send(2);
    make_frame(60, 1'b0); to_nibs(); nq = nq[0:16]; eq = eq[0:16]; send(2);
    // rx_er inside preamble kills the frame.
    make_frame(60, 1'b0); to_nibs(); eq[8] = 1'b1; send(2);
    check_stats();

    // Randomized frames with short gaps (down to a single idle cycle).
    for (int unsigned f = 0; f < 12; f++) begin
      make_frame($urandom_range(150, 56), ($urandom_range(3, 0) == 0));
      to_nibs();
      if ($urandom_range(4, 0) == 0) eq[$urandom_range(nq.size() - 1, 16)] = 1'b1;
      if ($urandom_range(5, 0) == 0) begin
        nq.push_back(4'($urandom));
        eq.push_back(1'b0);
      end
      send($urandom_range(3, 1));
    end
    check_stats();

    // Reset asserted at data byte 20 while dv stays high.
    make_frame(100, 1'b0); to_nibs();
    ignore_beats = 1'b1;
    for (int unsigned k = 0; k < nq.size(); k++) begin
      @(negedge clk);
      if (k == 56) resetn = 1'b0;
      if (k == 57) begin
        check("midrst_tvalid", 32'(m_axis_tvalid), 32'd0);
        check("midrst_tdata", 32'(m_axis_tdata), 32'd0);
        check("midrst_stat_good", 32'(stat_good), 32'd0);
        check("midrst_stat_bad", 32'(stat_bad), 32'd0);
        resetn = 1'b1;
      end
      dv = 1'b1;
      rx_data = nq[k];
      er = eq[k];
    end
    @(negedge clk);
    dv = 1'b0;
    repeat (5) @(negedge clk);
    ignore_beats = 1'b0;
    check("midrst_no_tlast", 32'(ign_tlast), 32'd0);
    exp_good = '0;
    exp_bad = '0;
    check_stats();
    make_frame(70, 1'b0); to_nibs(); send(3);
    check_stats();

    repeat (5) @(negedge clk);
    check("pending_beats", 32'(exp_q.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
    $finish;
  end

endmodule
